// File: rtl/instr_loader_pkg.sv
// Shared types and sizes for the boot-time instruction loader.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHK,
    DONE,
    ERR
  } state_e;

  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_W          = 8 * LEN_BYTES;
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
  localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/instr_loader_byte_packer.sv
// byte_packer: shifts stream bytes into a big-endian word and pulses word_valid
// for one cycle after the last byte of each word has been accepted.
module byte_packer
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic [IDX_W-1:0]  idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  // Shift register, byte index and completion pulse
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      word       <= '0;
      idx        <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= accept && (idx == LAST_IDX);
      if (accept) begin
        word <= {word[WORD_W-9:0], data};
        idx  <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: boot-time program loader feeding the instruction-memory write port.
// Frame: LEN_HI, LEN_LO (word count N), 4*N data bytes, optional checksum byte.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing checksum byte.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_e FRAME_END = CHK;
`else
  localparam state_e FRAME_END = DONE;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  state_e            state_q, state_d;
  logic              accept_c, take_req_c, pack_accept_c, word_last_c;
  logic [7:0]        len_hi_q;
  logic [LEN_W-1:0]  len_q, len_c;
  logic [IDX_W-1:0]  idx;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
`endif

  assign accept_c      = rx_valid & rx_ready;
  assign pack_accept_c = accept_c & (state_q == DATA);
  assign len_c         = {len_hi_q, rx_data};
  assign word_last_c   = (idx == LAST_IDX) && ((words_loaded + 16'd1) == len_q);

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    take_req_c = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (load_req) begin
          state_d    = LEN_HI;
          take_req_c = 1'b1;
        end
      end
      LEN_HI: if (accept_c) state_d = LEN_LO;
      LEN_LO: begin
        if (accept_c) begin
          if (32'(len_c) > MAX_WORDS) state_d = ERR;
          else if (len_c == '0)       state_d = FRAME_END;
          else                        state_d = DATA;
        end
      end
      DATA: if (accept_c && word_last_c) state_d = FRAME_END;
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (accept_c) state_d = (8'(sum_q + rx_data) == 8'd0) ? DONE : ERR;
      end
`else
      CHK: state_d = ERR;
`endif
      default: state_d = IDLE;
    endcase
  end

  // State register and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rx_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_start <= 1'b1;
    end else begin
      state_q   <= state_d;
      rx_ready  <= state_d inside {LEN_HI, LEN_LO, DATA, CHK};
      busy      <= state_d inside {LEN_HI, LEN_LO, DATA, CHK};
      done      <= (state_d == DONE);
      error     <= (state_d == ERR);
      cpu_start <= (state_d != DONE);
    end
  end

  // Header capture, write address and word counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_hi_q     <= '0;
      len_q        <= '0;
      words_loaded <= '0;
      imem_addr    <= '0;
    end else if (take_req_c) begin
      len_q        <= '0;
      words_loaded <= '0;
    end else begin
      if (accept_c && state_q == LEN_HI) len_hi_q <= rx_data;
      if (accept_c && state_q == LEN_LO) len_q    <= len_c;
      if (pack_accept_c && idx == LAST_IDX) begin
        imem_addr    <= ADDR_W'(BASE_ADDR) + ADDR_W'(words_loaded) * ADDR_W'(BYTES_PER_WORD);
        words_loaded <= words_loaded + 16'd1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running mod-256 sum over header and data bytes
  always_ff @(posedge clk) begin
    if (!rst_n || take_req_c) begin
      sum_q <= '0;
    end else if (accept_c && state_q inside {LEN_HI, LEN_LO, DATA}) begin
      sum_q <= sum_q + rx_data;
    end
  end
`endif

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (take_req_c),
    .accept     (pack_accept_c),
    .data       (rx_data),
    .word       (imem_wdata),
    .word_valid (imem_we),
    .idx        (idx)
  );

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader (default parameters).
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst_n, load_req, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, imem_we, cpu_start, busy, done, error;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] words_loaded;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_we  = -100;
  int b2b      = 0;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];

  instr_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_req     (load_req),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_start    (cpu_start),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every write strobe and flag writes closer than 4 cycles apart
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wq_addr.push_back(imem_addr);
      wq_data.push_back(imem_wdata);
      if (cyc - last_we < 4) b2b++;
      last_we = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_pulse();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Present one byte (called at a negedge), wait bounded for acceptance
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
    @(negedge clk);
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; load_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_cpu_start", {31'd0, cpu_start}, 32'd1);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_done",      {31'd0, done},      32'd0);
    check("rst_error",     {31'd0, error},     32'd0);
    check("rst_rx_ready",  {31'd0, rx_ready},  32'd0);
    check("rst_imem_we",   {31'd0, imem_we},   32'd0);
    check("rst_words",     {16'd0, words_loaded}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Two-word program, continuous stream
    load_pulse();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_word(32'h2008_0005, 0); send_word(32'h0000_0000, 0);
    idle(3);
    check("t1_nwrites", wq_addr.size(), 32'd2);
    check("t1_addr0", wq_addr[0], 32'h0);
    check("t1_data0", wq_data[0], 32'h2008_0005);
    check("t1_addr1", wq_addr[1], 32'h4);
    check("t1_data1", wq_data[1], 32'h0);
    check("t1_done",  {31'd0, done},      32'd1);
    check("t1_start", {31'd0, cpu_start}, 32'd0);
    check("t1_words", {16'd0, words_loaded}, 32'd2);

    // Reload from DONE, gappy stream, stray load_req mid-DATA
    wq_addr.delete(); wq_data.delete();
    load_pulse();
    check("t6_start", {31'd0, cpu_start}, 32'd1);
    check("t6_done",  {31'd0, done},      32'd0);
    check("t6_busy",  {31'd0, busy},      32'd1);
    check("t6_words", {16'd0, words_loaded}, 32'd0);
    send_byte(8'h00, 1); send_byte(8'h02, 1);
    send_byte(8'h20, 1); send_byte(8'h08, 1);
    load_pulse();
    check("t6_busy_ign", {31'd0, busy}, 32'd1);
    send_byte(8'h00, 1); send_byte(8'h05, 1);
    send_word(32'h0000_0000, 1);
    idle(3);
    check("t2_nwrites", wq_addr.size(), 32'd2);
    check("t2_addr0", wq_addr[0], 32'h0);
    check("t2_data0", wq_data[0], 32'h2008_0005);
    check("t2_addr1", wq_addr[1], 32'h4);
    check("t2_data1", wq_data[1], 32'h0);
    check("t2_words", {16'd0, words_loaded}, 32'd2);
    check("t2_done",  {31'd0, done}, 32'd1);

    // Oversize header -> ERR, no writes
    wq_addr.delete(); wq_data.delete();
    load_pulse();
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    idle(4);
    check("t3_error",   {31'd0, error},     32'd1);
    check("t3_start",   {31'd0, cpu_start}, 32'd1);
    check("t3_done",    {31'd0, done},      32'd0);
    check("t3_ready",   {31'd0, rx_ready},  32'd0);
    check("t3_nwrites", wq_addr.size(),     32'd0);

    // Empty program N=0
    load_pulse();
    check("n0_err_clr", {31'd0, error}, 32'd0);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    idle(3);
    check("n0_done",    {31'd0, done}, 32'd1);
    check("n0_words",   {16'd0, words_loaded}, 32'd0);
    check("n0_nwrites", wq_addr.size(), 32'd0);

    // Reset mid-load, then fresh single-word load
    load_pulse();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_word(32'h1122_3344, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("t4_rst_busy",  {31'd0, busy},      32'd0);
    check("t4_rst_start", {31'd0, cpu_start}, 32'd1);
    check("t4_rst_words", {16'd0, words_loaded}, 32'd0);
    rst_n = 1'b1;
    idle(1);
    load_pulse();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_word(32'hDEAD_BEEF, 0);
    idle(3);
    check("t4_nwrites", wq_addr.size(), 32'd2);
    check("t4_data0",   wq_data[0], 32'h1122_3344);
    check("t4_addr1",   wq_addr[1], 32'h0);
    check("t4_data1",   wq_data[1], 32'hDEAD_BEEF);
    check("t4_words",   {16'd0, words_loaded}, 32'd1);
    check("t4_done",    {31'd0, done}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // 00+01+AA+BB+CC+DD = 0x0F mod 256, so CHK 0xF1 balances to zero
    wq_addr.delete(); wq_data.delete();
    load_pulse();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_word(32'hAABB_CCDD, 0);
    send_byte(8'hF1, 0);
    idle(3);
    check("t5_pass_done", {31'd0, done}, 32'd1);
    load_pulse();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_word(32'hAABB_CCDD, 0);
    send_byte(8'h00, 0);
    idle(3);
    check("t5_fail_err",   {31'd0, error},     32'd1);
    check("t5_fail_done",  {31'd0, done},      32'd0);
    check("t5_fail_start", {31'd0, cpu_start}, 32'd1);
    check("t5_nwrites",    wq_addr.size(),     32'd2);
`endif

    check("write_spacing", b2b, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
